// File: rtl/irs_readout_pkg.sv
// ============================================================================
// Module      : irs_readout_pkg
// Description : Shared constants, word layouts and FSM encoding for the IRS
//               block readout sequencer.
// Options     : IRS_READOUT_CHECKSUM_EN adds the CKSUM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irs_readout_pkg;

  // Output stream word width
  localparam int WORD_W = 16;

  // Closing word of a block when no further blocks follow in the event
  localparam logic [WORD_W-1:0] TRAILER_WORD = 16'hE0F0;

  // Header word 0 layout: {trigger, zero pad, block}
  localparam int HDR_TRIG_W  = 4;
  localparam int HDR_PAD_W   = 3;
  localparam int HDR_BLOCK_W = 9;
  // Header word 1 layout: {1'b0, timestamp}
  localparam int HDR_TS_W    = 15;

  // Sample word layout: {channel, 1'b0, sample}
  localparam int SMP_CH_W    = 3;
  localparam int SMP_DATA_W  = 12;

  // Descriptor layout: block at the bottom, then timestamp, then trigger
  localparam int DESC_BLOCK_LSB = 0;

  function automatic int desc_ts_lsb(input int block_w);
    return DESC_BLOCK_LSB + block_w;
  endfunction

  function automatic int desc_trig_lsb(input int block_w, input int ts_w);
    return desc_ts_lsb(block_w) + ts_w;
  endfunction

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_HDR0  = 4'd1,
    ST_HDR1  = 4'd2,
    ST_REQ   = 4'd3,
    ST_WAIT  = 4'd4,
    ST_PUSH  = 4'd5,
    ST_TRAIL = 4'd6,
    ST_DONE  = 4'd7
`ifdef IRS_READOUT_CHECKSUM_EN
    , ST_CKSUM = 4'd8
`endif
  } state_t;

endpackage

`default_nettype wire

// File: rtl/irs_sample_fetch.sv
// ============================================================================
// Module      : irs_sample_fetch
// Description : Times the IRS read latency after a request and captures the
//               returned sample. valid is high in the cycle the sample is
//               on irs_data; sample holds the captured value afterwards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irs_sample_fetch #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int IRS_LATENCY  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [SAMPLE_WIDTH-1:0] irs_data,
  output logic [SAMPLE_WIDTH-1:0] sample,
  output logic                    valid
);

  localparam int CNT_W = $clog2(IRS_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT = CNT_W'(IRS_LATENCY);

  logic             active;
  logic [CNT_W-1:0] cnt;

  // cnt holds the number of cycles elapsed since the request cycle
  assign valid = active && (cnt == LAT);

  // Latency counter and capture register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      cnt    <= '0;
      sample <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CNT_W'(1);
    end else if (valid) begin
      active <= 1'b0;
      cnt    <= '0;
      sample <= irs_data;
    end else if (active) begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/irs_block_readout_sequencer.sv
// ============================================================================
// Module      : irs_block_readout_sequencer
// Description : Takes one queued block descriptor per read strobe, fetches
//               every sample of the block from the IRS and emits a framed
//               16-bit word stream (header, samples, optional trailer).
//               Pulses read_done_o once the block has been fully emitted.
// Options     : `define IRS_READOUT_CHECKSUM_EN to append an XOR checksum
//               word after the last sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irs_block_readout_sequencer
  import irs_readout_pkg::*;
#(
  parameter int RB_WIDTH        = 35,
  parameter int BLOCK_WIDTH     = 9,
  parameter int TIMESTAMP_WIDTH = 15,
  parameter int TRIG_WIDTH      = 4,
  parameter int N_CHANNELS      = 8,
  parameter int N_SAMPLES       = 64,
  parameter int SAMPLE_WIDTH    = 12,
  parameter int IRS_LATENCY     = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [RB_WIDTH-1:0]     read_block_i,
  input  logic                    read_strobe_i,
  input  logic                    read_remaining_i,
  output logic                    read_done_o,
  output logic                    irs_rd_o,
  output logic [BLOCK_WIDTH+$clog2(N_CHANNELS)+$clog2(N_SAMPLES)-1:0] irs_addr_o,
  input  logic [SAMPLE_WIDTH-1:0] irs_data_i,
  output logic [WORD_W-1:0]       dat_o,
  output logic                    dat_valid_o,
  input  logic                    dat_ready_i,
  output logic                    busy_o
);

  localparam int CH_W      = $clog2(N_CHANNELS);
  localparam int SMP_W     = $clog2(N_SAMPLES);
  localparam int TS_LSB    = desc_ts_lsb(BLOCK_WIDTH);
  localparam int TRIG_LSB  = desc_trig_lsb(BLOCK_WIDTH, TIMESTAMP_WIDTH);
  localparam int DESC_USED = TRIG_LSB + TRIG_WIDTH;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CHANNELS - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(N_SAMPLES - 1);

  logic [1:0] rst_sync;
  logic       rst_n;

  state_t state, state_nx;

  logic [BLOCK_WIDTH-1:0]     blk_q;
  logic [TIMESTAMP_WIDTH-1:0] ts_q;
  logic [TRIG_WIDTH-1:0]      trig_q;
  logic                       remaining_q;
  logic [CH_W-1:0]            ch_q;
  logic [SMP_W-1:0]           smp_q;

  logic                       fetch_start;
  logic                       fetch_valid;
  logic [SAMPLE_WIDTH-1:0]    fetch_sample;

  logic                       accept;
  logic                       last_sample;
  logic [WORD_W-1:0]          hdr0_word;
  logic [WORD_W-1:0]          hdr1_word;
  logic [WORD_W-1:0]          smp_word;
  state_t                     tail_state;

  // Descriptor bits above the trigger field carry nothing for this block
  generate
    if (RB_WIDTH > DESC_USED) begin : g_desc_spare
      logic unused_desc_bits;
      assign unused_desc_bits = ^read_block_i[RB_WIDTH-1:DESC_USED];
    end
  endgenerate

  // Reset asserts asynchronously and releases on a clock edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign accept      = dat_valid_o && dat_ready_i;
  assign last_sample = (ch_q == CH_LAST) && (smp_q == SMP_LAST);
  assign hdr0_word   = {HDR_TRIG_W'(trig_q), {HDR_PAD_W{1'b0}}, HDR_BLOCK_W'(blk_q)};
  assign hdr1_word   = {1'b0, HDR_TS_W'(ts_q)};
  assign smp_word    = {SMP_CH_W'(ch_q), 1'b0, SMP_DATA_W'(fetch_sample)};
  assign tail_state  = remaining_q ? ST_DONE : ST_TRAIL;

  irs_sample_fetch #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .IRS_LATENCY  (IRS_LATENCY)
  ) u_fetch (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (fetch_start),
    .irs_data (irs_data_i),
    .sample   (fetch_sample),
    .valid    (fetch_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Descriptor latch and channel-major sample counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q       <= '0;
      ts_q        <= '0;
      trig_q      <= '0;
      remaining_q <= 1'b0;
      ch_q        <= '0;
      smp_q       <= '0;
    end else if (state == ST_IDLE && read_strobe_i) begin
      blk_q       <= read_block_i[DESC_BLOCK_LSB +: BLOCK_WIDTH];
      ts_q        <= read_block_i[TS_LSB +: TIMESTAMP_WIDTH];
      trig_q      <= read_block_i[TRIG_LSB +: TRIG_WIDTH];
      remaining_q <= read_remaining_i;
      ch_q        <= '0;
      smp_q       <= '0;
    end else if (state == ST_PUSH && accept) begin
      if (smp_q == SMP_LAST) begin
        smp_q <= '0;
        ch_q  <= ch_q + CH_W'(1);
      end else begin
        smp_q <= smp_q + SMP_W'(1);
      end
    end
  end

`ifdef IRS_READOUT_CHECKSUM_EN
  logic [WORD_W-1:0] cksum_q;

  // XOR of every accepted header and sample word of the current block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cksum_q <= '0;
    else if (state == ST_IDLE)   cksum_q <= '0;
    else if (accept && (state == ST_HDR0 || state == ST_HDR1 || state == ST_PUSH))
                                 cksum_q <= cksum_q ^ dat_o;
  end
`endif

  // Next-state decode and output framing
  always_comb begin
    state_nx    = state;
    dat_o       = '0;
    dat_valid_o = 1'b0;
    irs_rd_o    = 1'b0;
    irs_addr_o  = '0;
    read_done_o = 1'b0;
    busy_o      = 1'b0;
    fetch_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (read_strobe_i) state_nx = ST_HDR0;
      end
      ST_HDR0: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        dat_o       = hdr0_word;
        if (dat_ready_i) state_nx = ST_HDR1;
      end
      ST_HDR1: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        dat_o       = hdr1_word;
        if (dat_ready_i) state_nx = ST_REQ;
      end
      ST_REQ: begin
        busy_o      = 1'b1;
        irs_rd_o    = 1'b1;
        irs_addr_o  = {blk_q, ch_q, smp_q};
        fetch_start = 1'b1;
        state_nx    = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o = 1'b1;
        if (fetch_valid) state_nx = ST_PUSH;
      end
      ST_PUSH: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        dat_o       = smp_word;
        if (dat_ready_i) begin
`ifdef IRS_READOUT_CHECKSUM_EN
          state_nx = last_sample ? ST_CKSUM : ST_REQ;
`else
          state_nx = last_sample ? tail_state : ST_REQ;
`endif
        end
      end
`ifdef IRS_READOUT_CHECKSUM_EN
      ST_CKSUM: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        dat_o       = cksum_q;
        if (dat_ready_i) state_nx = tail_state;
      end
`endif
      ST_TRAIL: begin
        busy_o      = 1'b1;
        dat_valid_o = 1'b1;
        dat_o       = TRAILER_WORD;
        if (dat_ready_i) state_nx = ST_DONE;
      end
      ST_DONE: begin
        read_done_o = 1'b1;
        state_nx    = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_irs_block_readout_sequencer.sv
// ============================================================================
// Module      : tb_irs_block_readout_sequencer
// Description : Directed, table-driven bench for the IRS block readout
//               sequencer (2 channels x 4 samples, IRS latency 3) with an
//               address-derived IRS sample model and a mid-block reset case.
// Options     : IRS_READOUT_CHECKSUM_EN expects the extra checksum word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irs_block_readout_sequencer;

  localparam int LAT = 3;
`ifdef IRS_READOUT_CHECKSUM_EN
  localparam int CKW = 1;
`else
  localparam int CKW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [34:0] read_block_i = '0;
  logic        read_strobe_i = 1'b0;
  logic        read_remaining_i = 1'b0;
  logic        read_done_o;
  logic        irs_rd_o;
  logic [11:0] irs_addr_o;
  logic [11:0] irs_data_i = '0;
  logic [15:0] dat_o;
  logic        dat_valid_o;
  logic        dat_ready_i = 1'b0;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  irs_block_readout_sequencer #(
    .N_CHANNELS  (2),
    .N_SAMPLES   (4),
    .IRS_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .read_block_i     (read_block_i),
    .read_strobe_i    (read_strobe_i),
    .read_remaining_i (read_remaining_i),
    .read_done_o      (read_done_o),
    .irs_rd_o         (irs_rd_o),
    .irs_addr_o       (irs_addr_o),
    .irs_data_i       (irs_data_i),
    .dat_o            (dat_o),
    .dat_valid_o      (dat_valid_o),
    .dat_ready_i      (dat_ready_i),
    .busy_o           (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // IRS sample contents as a function of the requested address
  function automatic logic [11:0] samp_of(input logic [11:0] a);
    return a ^ 12'h5A5;
  endfunction

  // IRS model: data appears LAT cycles after the request, noise otherwise
  int          cyc = 0;
  bit          pend = 1'b0;
  int          due = 0;
  logic [11:0] pend_addr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      pend = 1'b0;
    end else begin
      if (pend && due == cyc) begin
        irs_data_i = samp_of(pend_addr);
        pend = 1'b0;
      end else begin
        irs_data_i = 12'($urandom);
      end
      if (irs_rd_o) begin
        check("single_outstanding", {31'd0, pend}, 32'd0);
        pend = 1'b1;
        due = cyc + LAT;
        pend_addr = irs_addr_o;
      end
    end
  end

  typedef struct {
    logic [8:0]  blk;
    logic [14:0] ts;
    logic [3:0]  trig;
    logic        rem;
    int          ready_pct;
    logic [15:0] hdr0;
    logic [15:0] hdr1;
    int          n_words;
  } vec_t;

  task automatic run_block(input vec_t v, input int tag);
    logic [15:0] exp_q[$];
    logic [15:0] ck;
    logic [15:0] held;
    int idx, cycles;
    bit stalled, finished;
    exp_q.push_back(v.hdr0);
    exp_q.push_back(v.hdr1);
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 4; s++)
        exp_q.push_back({3'(c), 1'b0, samp_of({v.blk, 1'(c), 2'(s)})});
    ck = '0;
    foreach (exp_q[i]) ck ^= exp_q[i];
    if (CKW == 1) exp_q.push_back(ck);
    if (!v.rem) exp_q.push_back(16'hE0F0);

    check($sformatf("v%0d_idle_busy", tag), {31'd0, busy_o}, 32'd0);
    read_block_i     = {7'h55, v.trig, v.ts, v.blk};
    read_remaining_i = v.rem;
    read_strobe_i    = 1'b1;
    @(negedge clk);
    read_strobe_i    = 1'b0;
    read_block_i     = 35'($urandom);
    read_remaining_i = 1'($urandom);
    check($sformatf("v%0d_busy_after_strobe", tag), {31'd0, busy_o}, 32'd1);

    idx = 0; cycles = 0; stalled = 1'b0; finished = 1'b0; held = '0;
    while (!finished && cycles < 4000) begin
      dat_ready_i = ($urandom_range(0, 99) < v.ready_pct);
      if (stalled) begin
        check($sformatf("v%0d_stall_valid", tag), {31'd0, dat_valid_o}, 32'd1);
        check($sformatf("v%0d_stall_data", tag), {16'd0, dat_o}, {16'd0, held});
      end
      check($sformatf("v%0d_no_rd_while_valid", tag), {31'd0, irs_rd_o && dat_valid_o}, 32'd0);
      if (dat_valid_o && dat_ready_i) begin
        if (idx < exp_q.size())
          check($sformatf("v%0d_word%0d", tag, idx), {16'd0, dat_o}, {16'd0, exp_q[idx]});
        else
          check($sformatf("v%0d_extra_word", tag), 32'd1, 32'd0);
        idx++;
      end
      if (read_done_o) begin
        check($sformatf("v%0d_done_after_last", tag), idx, v.n_words + CKW);
        check($sformatf("v%0d_busy_in_done", tag), {31'd0, busy_o}, 32'd0);
        finished = 1'b1;
      end
      stalled = dat_valid_o && !dat_ready_i;
      held    = dat_o;
      @(negedge clk);
      cycles++;
    end
    if (!finished) check($sformatf("v%0d_timeout", tag), 32'd1, 32'd0);
    check($sformatf("v%0d_done_one_cycle", tag), {31'd0, read_done_o}, 32'd0);
    check($sformatf("v%0d_idle_after", tag), {31'd0, busy_o}, 32'd0);
    dat_ready_i = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    int n_acc, guard;
    bit seen_done;
    vecs[0] = '{blk: 9'h1A5, ts: 15'h1234, trig: 4'h5, rem: 1'b0, ready_pct: 100,
                hdr0: 16'h51A5, hdr1: 16'h1234, n_words: 11};
    vecs[1] = '{blk: 9'h1A5, ts: 15'h1234, trig: 4'h5, rem: 1'b1, ready_pct: 100,
                hdr0: 16'h51A5, hdr1: 16'h1234, n_words: 10};
    vecs[2] = '{blk: 9'h1A5, ts: 15'h1234, trig: 4'h5, rem: 1'b0, ready_pct: 70,
                hdr0: 16'h51A5, hdr1: 16'h1234, n_words: 11};
    vecs[3] = '{blk: 9'h0FF, ts: 15'h7FFF, trig: 4'hF, rem: 1'b1, ready_pct: 60,
                hdr0: 16'hF0FF, hdr1: 16'h7FFF, n_words: 10};
    vecs[4] = '{blk: 9'h000, ts: 15'h0000, trig: 4'h0, rem: 1'b0, ready_pct: 100,
                hdr0: 16'h0000, hdr1: 16'h0000, n_words: 11};

    // Reset state
    #12;
    check("rst_valid", {31'd0, dat_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_rd", {31'd0, irs_rd_o}, 32'd0);
    check("rst_done", {31'd0, read_done_o}, 32'd0);
    check("rst_dat", {16'd0, dat_o}, 32'd0);
    check("rst_addr", {20'd0, irs_addr_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i], i);
      repeat (1 + i) @(negedge clk);
    end

    // Reset while a sample word is being offered
    read_block_i     = {7'h00, 4'h5, 15'h1234, 9'h1A5};
    read_remaining_i = 1'b0;
    read_strobe_i    = 1'b1;
    dat_ready_i      = 1'b1;
    @(negedge clk);
    read_strobe_i = 1'b0;
    n_acc = 0; guard = 0;
    while (guard < 200 && !(n_acc >= 2 && dat_valid_o)) begin
      if (dat_valid_o && dat_ready_i) n_acc++;
      @(negedge clk);
      guard++;
    end
    dat_ready_i = 1'b0;
    check("mid_push_reached", {31'd0, dat_valid_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, dat_valid_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    check("mid_rst_dat", {16'd0, dat_o}, 32'd0);
    check("mid_rst_done", {31'd0, read_done_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (read_done_o) seen_done = 1'b1;
    end
    check("no_done_after_reset", {31'd0, seen_done}, 32'd0);
    run_block(vecs[0], 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
